// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: sync, blanking, coordinates, look-ahead pixel
// requests and line/frame start pulses, all registered from the next-state counters.
module vga_timing_gen #(
    parameter int H_FRONT = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_ACT   = 640,
    parameter int V_FRONT = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_ACT   = 480,
    parameter int HS_POL  = 0,
    parameter int VS_POL  = 0,
    parameter int LEAD    = 1,
    parameter int CW      = 11
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_pix_en,
    output logic          o_hs,
    output logic          o_vs,
    output logic          o_blank_n,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_req,
    output logic [CW-1:0] o_req_x,
    output logic [CW-1:0] o_req_y,
    output logic          o_line_start,
    output logic          o_frame_start
);

    localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
    localparam int H_TOTAL = H_BLANK + H_ACT;
    localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;
    localparam int V_TOTAL = V_BLANK + V_ACT;
    localparam int WX      = CW + 1;

    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic          HS_ACT  = (HS_POL != 0);
    localparam logic          VS_ACT  = (VS_POL != 0);

    logic [CW-1:0] hCnt_q, hCnt_d;
    logic [CW-1:0] vCnt_q, vCnt_d;
    logic          hWrap, vWrap;

    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          blank_q, blank_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          req_q, req_d;
    logic [CW-1:0] reqX_q, reqX_d;
    logic [CW-1:0] reqY_q, reqY_d;
    logic          lineStart_q;
    logic          frameStart_q;

    logic [CW:0]   hExt, vExt, reqSum;
    logic          vActive;

    always_comb begin
        hCnt_d = hCnt_q;
        vCnt_d = vCnt_q;
        hWrap  = 1'b0;
        vWrap  = 1'b0;
        if (i_pix_en) begin
            if (hCnt_q == H_LAST) begin
                hCnt_d = '0;
                hWrap  = 1'b1;
                if (vCnt_q == V_LAST) begin
                    vCnt_d = '0;
                    vWrap  = 1'b1;
                end else begin
                    vCnt_d = vCnt_q + ONE;
                end
            end else begin
                hCnt_d = hCnt_q + ONE;
            end
        end
    end

    // Decode from the next-state counters so registered outputs line up with the counters.
    always_comb begin
        hExt    = {1'b0, hCnt_d};
        vExt    = {1'b0, vCnt_d};
        reqSum  = hExt + WX'(LEAD);
        vActive = (vExt >= WX'(V_BLANK));

        hs_d    = ((hExt >= WX'(H_FRONT)) && (hExt < WX'(H_FRONT + H_SYNC))) ? HS_ACT : ~HS_ACT;
        vs_d    = ((vExt >= WX'(V_FRONT)) && (vExt < WX'(V_FRONT + V_SYNC))) ? VS_ACT : ~VS_ACT;

        blank_d = (hExt >= WX'(H_BLANK)) && vActive;
        x_d     = blank_d ? (hCnt_d - CW'(H_BLANK)) : '0;
        y_d     = blank_d ? (vCnt_d - CW'(V_BLANK)) : '0;

        req_d   = (reqSum >= WX'(H_BLANK)) && (reqSum < WX'(H_TOTAL)) && vActive;
        reqX_d  = req_d ? (hCnt_d + CW'(LEAD) - CW'(H_BLANK)) : '0;
        reqY_d  = req_d ? (vCnt_d - CW'(V_BLANK)) : '0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            hCnt_q       <= '0;
            vCnt_q       <= '0;
            hs_q         <= ~HS_ACT;
            vs_q         <= ~VS_ACT;
            blank_q      <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            req_q        <= 1'b0;
            reqX_q       <= '0;
            reqY_q       <= '0;
            lineStart_q  <= 1'b0;
            frameStart_q <= 1'b0;
        end else begin
            hCnt_q       <= hCnt_d;
            vCnt_q       <= vCnt_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            blank_q      <= blank_d;
            x_q          <= x_d;
            y_q          <= y_d;
            req_q        <= req_d;
            reqX_q       <= reqX_d;
            reqY_q       <= reqY_d;
            lineStart_q  <= hWrap;
            frameStart_q <= vWrap;
        end
    end

    assign o_hs          = hs_q;
    assign o_vs          = vs_q;
    assign o_blank_n     = blank_q;
    assign o_x           = x_q;
    assign o_y           = y_q;
    assign o_req         = req_q;
    assign o_req_x       = reqX_q;
    assign o_req_y       = reqY_q;
    assign o_line_start  = lineStart_q;
    assign o_frame_start = frameStart_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised single-clock VGA/raster timing generator. Successor to the existing 640x480 controller.
- Horizontal and vertical counters share one clock, gated by a pixel-enable. Timings, sync polarities and counter width are parameters.
- Adds a look-ahead pixel request (o_req, o_req_x, o_req_y) so a frame-buffer or renderer with fixed LEAD-cycle latency has data ready when the pixel is displayed.
- Adds frame-start and line-start pulses. Sits between the system clock domain and the VGA DAC; the DAC clock is generated outside this block.

Parameters:
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width
H_BACK, 48, horizontal back porch
H_ACT, 640, active pixels per line
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BACK, 33, vertical back porch
V_ACT, 480, active lines per frame
HS_POL, 0, HS active level (0 = active-low)
VS_POL, 0, VS active level
LEAD, 1, request lead in pixels; legal range 0..H_FRONT+H_SYNC+H_BACK
CW, 11, counter/coordinate width; H_TOTAL and V_TOTAL must each be ≤ 2^CW

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  synchronous active-low reset
i_pix_en  in  1  pixel advance enable; counters step only when high
o_hs  out  1  horizontal sync
o_vs  out  1  vertical sync
o_blank_n  out  1  high in the active display region
o_x  out  CW  active-region x; 0 outside the active region
o_y  out  CW  active-region y; 0 outside the active region
o_req  out  1  pixel request, LEAD pixels ahead of display
o_req_x  out  CW  x of the requested pixel; 0 when o_req is low
o_req_y  out  CW  y of the requested pixel; 0 when o_req is low
o_line_start  out  1  one-cycle pulse when h_cnt wraps to 0
o_frame_start  out  1  one-cycle pulse when (h_cnt,v_cnt) wraps to (0,0)

Behaviour:
- Derived quantities: H_BLANK = H_FRONT+H_SYNC+H_BACK, H_TOTAL = H_BLANK+H_ACT; V_BLANK and V_TOTAL defined likewise.
- Line order is FRONT, SYNC, BACK, ACTIVE. The frame uses the same order in lines.
- Reset is synchronous and active-low; one clock clock with i_reset_n low is sufficient, and it overrides i_pix_en. Reset values:
  - h_cnt = v_cnt = 0
  - o_hs = ~HS_POL, o_vs = ~VS_POL
  - o_blank_n, o_req, o_line_start, o_frame_start all 0
  - all coordinate outputs 0
- Reset mid-frame: counters and outputs return to these values on the next edge. No partial-line state survives.
- Counter advance, on each clock with i_pix_en=1:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0.
  - On that wrap v_cnt increments; at V_TOTAL-1 it wraps to 0.
- With i_pix_en=0, counters and all level outputs hold, and both pulse outputs are 0.
- All outputs are registered. They are decoded from the next-state counter values, so they are aligned with the counter registers with zero skew and are glitch-free.
- Sync and blanking decode:
  - o_hs = HS_POL while H_FRONT ≤ h_cnt < H_FRONT+H_SYNC.
  - o_vs = VS_POL while V_FRONT ≤ v_cnt < V_FRONT+V_SYNC.
  - o_vs changes only on the h_cnt wrap edge.
  - o_blank_n = (h_cnt ≥ H_BLANK) && (v_cnt ≥ V_BLANK).
  - When o_blank_n=1: o_x = h_cnt-H_BLANK, o_y = v_cnt-V_BLANK, arithmetic in CW bits with no overflow given the legal parameters.
- Request decode:
  - o_req = 1 when (h_cnt+LEAD) ≥ H_BLANK, h_cnt+LEAD < H_TOTAL, and v_cnt ≥ V_BLANK.
  - When o_req=1: o_req_x = h_cnt+LEAD-H_BLANK and o_req_y = v_cnt-V_BLANK.
  - Requests never cross a line boundary because LEAD ≤ H_BLANK.
  - LEAD=0 makes o_req identical to o_blank_n.
- Pulses:
  - o_line_start is high for the single clock after an advance that wraps h_cnt to 0.
  - o_frame_start is high for the single clock after an advance that wraps both counters to (0,0).
  - Neither pulse is asserted on reset release; the first o_frame_start comes after one full frame.
- Frame length is exactly H_TOTAL*V_TOTAL pix_en cycles; defaults give 800*525 = 420000.

Test Plan:
- Defaults, i_pix_en=1: o_hs low for exactly 96 clocks starting at h_cnt=16, period 800. o_vs low for 2 lines (1600 clocks) starting at v_cnt=10. o_frame_start period 420000.
- Defaults, first active line (v_cnt=45): o_blank_n rises at h_cnt=160 with o_x=0, o_y=0. Last active pixel is at h_cnt=799 with o_x=639. Line v_cnt=524 ends with o_y=479, then wraps to (0,0) with o_frame_start=1.
- LEAD=2: o_req rises at h_cnt=158 with o_req_x=0 and falls at h_cnt=798. Total 640 requests per active line; no request on v_cnt<45. LEAD=0: o_req equals o_blank_n every cycle.
- i_pix_en toggling 1,0,1,0: HS low width is 192 clocks. All outputs hold during i_pix_en=0 cycles. Pulses stay one clock wide and occur only after enabled advances.
- Drive i_reset_n low for 1 clock at h_cnt=400, v_cnt=100: next edge gives counters 0, o_hs=1, o_vs=1, o_blank_n=0, coordinates 0, no pulse. The following frame re-times exactly from (0,0).
- Small config (H 2/2/2/8, V 1/1/1/4, HS_POL=1, VS_POL=1, CW=5): H_TOTAL=14, V_TOTAL=7. o_hs high for h_cnt 2..3. o_x runs 0..7. Frame period is 98 clocks.
